// File: rtl/subtrator_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and default width.
package subtrator_pkg;

   localparam int N_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/subtrator_bit.sv
// One-bit combinational full subtractor: dif = x - y - bi, bout is the borrow out.
module subtrator_bit (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic dif,
   output logic bout
);

   assign dif  = x ^ y ^ bi;
   assign bout = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial unsigned subtractor: d = (a - b) mod 2^N, one bit per clock, LSB first.
module subtrator_serial
   import subtrator_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] d,
   output logic         bo
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t        state;
   logic [N-1:0]  sa;
   logic [N-1:0]  sb;
   logic [N-1:0]  res;
   logic [CW-1:0] cnt;
   logic          br;
   logic          dif;
   logic          bout;

   subtrator_bit u_bit (
      .x    (sa[0]),
      .y    (sb[0]),
      .bi   (br),
      .dif  (dif),
      .bout (bout)
   );

   // d/bo are only written on the final SHIFT edge, so they hold the previous result
   // throughout a new operation and after it until the next completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sa    <= '0;
         sb    <= '0;
         res   <= '0;
         cnt   <= '0;
         br    <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         d     <= '0;
         bo    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  br    <= 1'b0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end else begin
                  state <= IDLE;
               end
            end
            SHIFT: begin
               sa  <= {1'b0, sa[N-1:1]};
               sb  <= {1'b0, sb[N-1:1]};
               res <= {dif, res[N-1:1]};
               br  <= bout;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  d     <= {dif, res[N-1:1]};
                  bo    <= bout;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_subtrator_serial.sv
// Directed self-checking bench for subtrator_serial (N=8 instance plus an N=4 sweep instance).
module tb_subtrator_serial;

   logic       clk;
   logic       rst_n;
   logic       start8;
   logic [7:0] a8;
   logic [7:0] b8;
   logic       busy8;
   logic       done8;
   logic [7:0] d8;
   logic       bo8;
   logic       start4;
   logic [3:0] a4;
   logic [3:0] b4;
   logic       busy4;
   logic       done4;
   logic [3:0] d4;
   logic       bo4;

   int checkCount = 0;
   int passCount  = 0;

   subtrator_serial #(.N(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .busy  (busy8),
      .done  (done8),
      .d     (d8),
      .bo    (bo8)
   );

   subtrator_serial #(.N(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start4),
      .a     (a4),
      .b     (b4),
      .busy  (busy4),
      .done  (done4),
      .d     (d4),
      .bo    (bo4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs === exp) passCount++;
      else $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // Drive an op at the negedge, let it be accepted, return #1 after the accepting edge.
   task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic hold);
      @(negedge clk);
      a8     = av;
      b8     = bv;
      start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = hold;
   endtask

   // Count edges since acceptance until done; optionally disturb b mid-operation.
   task automatic waitDone(input int chgAt, input logic [7:0] chgB, input logic [7:0] prevD,
                           output int lat, output int busyCnt);
      lat     = -1;
      busyCnt = 0;
      for (int c = 0; c <= 20; c++) begin
         checkOutput("busy_done_excl", {31'd0, busy8 & done8}, 32'd0);
         if (busy8) busyCnt++;
         if (c == 4) checkOutput("d_hold_in_shift", {24'd0, d8}, {24'd0, prevD});
         if (done8) begin
            lat = c;
            break;
         end
         if (c == chgAt) b8 = chgB;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic runOp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] prevD, input logic [7:0] expD, input logic expBo);
      int lat;
      int bc;
      applyStimulus(av, bv, 1'b0);
      waitDone(-1, 8'd0, prevD, lat, bc);
      checkOutput({tag, "_latency"}, lat, 32'd8);
      checkOutput({tag, "_d"}, {24'd0, d8}, {24'd0, expD});
      checkOutput({tag, "_bo"}, {31'd0, bo8}, {31'd0, expBo});
      @(posedge clk);
      #1;
      checkOutput({tag, "_done_pulse"}, {31'd0, done8}, 32'd0);
      checkOutput({tag, "_d_after"}, {24'd0, d8}, {24'd0, expD});
   endtask

   initial begin
      int lat;
      int bc;
      int dcount;
      logic [3:0] capD;
      logic       capBo;

      rst_n  = 1'b0;
      start8 = 1'b0;
      a8     = 8'd0;
      b8     = 8'd0;
      start4 = 1'b0;
      a4     = 4'd0;
      b4     = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_busy", {31'd0, busy8}, 32'd0);
      checkOutput("rst_done", {31'd0, done8}, 32'd0);
      checkOutput("rst_d", {24'd0, d8}, 32'd0);
      checkOutput("rst_bo", {31'd0, bo8}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      runOp("op5m3", 8'd5, 8'd3, 8'd0, 8'd2, 1'b0);
      runOp("op3m5", 8'd3, 8'd5, 8'd2, 8'hFE, 1'b1);
      runOp("op0m1", 8'd0, 8'd1, 8'hFE, 8'hFF, 1'b1);
      runOp("opffmff", 8'd255, 8'd255, 8'hFF, 8'd0, 1'b0);

      // start held high, b disturbed mid-SHIFT, then a back-to-back op from DONE
      applyStimulus(8'd100, 8'd37, 1'b1);
      waitDone(3, 8'd200, 8'd0, lat, bc);
      checkOutput("hold_latency", lat, 32'd8);
      checkOutput("hold_busy_cycles", bc, 32'd8);
      checkOutput("hold_d", {24'd0, d8}, 32'd63);
      checkOutput("hold_bo", {31'd0, bo8}, 32'd0);
      a8 = 8'd20;
      b8 = 8'd30;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      checkOutput("b2b_busy", {31'd0, busy8}, 32'd1);
      waitDone(-1, 8'd0, 8'd63, lat, bc);
      checkOutput("b2b_latency", lat, 32'd8);
      checkOutput("b2b_d", {24'd0, d8}, 32'd246);
      checkOutput("b2b_bo", {31'd0, bo8}, 32'd1);

      // asynchronous reset in the middle of SHIFT
      applyStimulus(8'd9, 8'd4, 1'b0);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", {31'd0, busy8}, 32'd0);
      checkOutput("abort_done", {31'd0, done8}, 32'd0);
      checkOutput("abort_d", {24'd0, d8}, 32'd0);
      checkOutput("abort_bo", {31'd0, bo8}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      dcount = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         if (done8) dcount++;
      end
      checkOutput("abort_no_done", dcount, 32'd0);
      runOp("op200m100", 8'd200, 8'd100, 8'd0, 8'd100, 1'b0);

      // exhaustive N=4 sweep
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            @(negedge clk);
            a4     = 4'(ia);
            b4     = 4'(ib);
            start4 = 1'b1;
            @(posedge clk);
            #1;
            start4 = 1'b0;
            dcount = 0;
            lat    = -1;
            capD   = 4'd0;
            capBo  = 1'b0;
            for (int c = 1; c <= 7; c++) begin
               @(posedge clk);
               #1;
               if (done4) begin
                  dcount++;
                  lat   = c;
                  capD  = d4;
                  capBo = bo4;
               end
            end
            checkOutput("sweep_done_once", dcount, 32'd1);
            checkOutput("sweep_latency", lat, 32'd4);
            checkOutput("sweep_d", {28'd0, capD}, 32'((ia - ib) & 15));
            checkOutput("sweep_bo", {31'd0, capBo}, {31'd0, (ia < ib)});
         end
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
